sd_demod: RTL and testbench
===========================

// Module: sd_demod
// PURPOSE
//  Receive side of the tone generator: decodes a 1-bit sigma-delta bitstream back into 8-bit samples.
//  Uses a 2nd-order CIC decimator and exposes the samples on an Avalon-MM slave read port.
//  Sits on a loopback of the modulator output (or an external comparator) for the Nios host to read back.
//  Optionally measures tone period in decimated samples.
// PARAMETERS
//  DEC_LOG2   4   log2 decimation ratio; DECIM = 2**DEC_LOG2; legal range 4..8
//  PER_WIDTH  16  width of period counter/register (ZCROSS_EN only)
// PORTS
//  clk      in   1   system clock; all logic on posedge
//  clr_n    in   1   reset, synchronous, active-low
//  din      in   1   sigma-delta bitstream, one bit per clk
//  rd_n     in   1   Avalon-MM read_n
//  addr     in   1   Avalon-MM address (word): 0 = SAMPLE/STATUS, 1 = PERIOD
//  rd_data  out  32  Avalon-MM readdata, registered
// BEHAVIOUR
//  - Reset (clr_n=0 at posedge): clears every register, including:
//      integrators, combs, decimation counter, warm-up counter, sample, valid, ovr, period, rd_data.
//    Outputs read 0 from the following cycle. Reset mid-frame discards the partial frame.
//  - Width: W = 2*DEC_LOG2+1 for integrators and combs. Integrator arithmetic is mod 2**W; wrap is legal.
//  - Every clk: int1 <= int1 + din; int2 <= int2 + int1.
//  - dcnt counts 0..DECIM-1 and wraps. Tick = (dcnt==DECIM-1).
//  - On tick: c1 <= int2 - int2_d; int2_d <= int2; c2 <= c1 - c1_d; c1_d <= c1 (all mod 2**W).
//  - Cycle after tick (load): sample <= sat8(c2 >> (2*DEC_LOG2-8)), where sat8 clamps values >255 to 255.
//    Gain is DECIM**2: all-ones gives 256, clamped to 255.
//  - Warm-up: the first 2 loads after reset update sample but do not set valid.
//  - Status and read handshake:
//      load (post warm-up):       valid <= 1.
//      load while valid=1, no addr-0 read same cycle: ovr <= 1.
//      rd_n=0 sampled at posedge: rd_data updates the next cycle (read latency 1); rd_n=1 holds rd_data.
//      addr 0 word: {valid, ovr, 22'b0, sample[7:0]} (bit31=valid, bit30=ovr), captured before update.
//      addr-0 read then clears valid and ovr.
//  - Simultaneous load and addr-0 read: rd_data returns the old sample with the old flags.
//    The new sample is stored, valid=1, ovr=0.
//  - addr 1 word: zero-extended period (ZCROSS_EN) or 32'h0.
//  - No write port; writes ignored (no wr_n pin).
// CONFIGURATION
//  - ZCROSS_EN defined:
//      pcnt increments per post-warm-up load, saturating at 2**PER_WIDTH-1.
//      Rising crossing = prev sample <128 and new sample >=128.
//      On a crossing: period <= pcnt+1; pcnt <= 0. The first crossing after reset only restarts pcnt.
//  - ZCROSS_EN undefined: no pcnt/period logic; addr 1 reads 32'h0.
// TESTING (DEC_LOG2=4 unless noted)
//  1. din=1 constant; read addr0 after 3rd tick -> rd_data=32'h800000FF; re-read -> valid=0.
//  2. din=0 constant -> sample 8'h00, valid=1 after 3rd load, ovr=1 after 4th if not read.
//  3. din alternating 1,0 -> steady sample 8'h80 (128) +-1 after warm-up.
//  4. Read asserted exactly on load cycle -> old sample returned, next read shows new sample, ovr=0.
//  5. clr_n low for 1 cycle mid-frame -> all regs 0 next cycle; first valid only after 3 new ticks.
//  6. ZCROSS_EN, din = 64 ones/64 zeros repeating -> addr1 reads 32'd8 after 2nd rising crossing.

Source files
------------

// File: rtl/sd_demod.sv
// sd_demod: 2nd-order CIC decoder that turns a 1-bit sigma-delta stream into 8-bit samples behind an Avalon-MM read port.
// Define ZCROSS_EN to add rising-crossing tone-period measurement on word address 1.
module sd_demod #(
  parameter int DEC_LOG2 = 4
`ifdef ZCROSS_EN
  ,parameter int PER_WIDTH = 16
`endif
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        din,
  input  logic        rd_n,
  input  logic        addr,
  output logic [31:0] rd_data
);

  localparam int W     = 2 * DEC_LOG2 + 1;
  localparam int SHIFT = 2 * DEC_LOG2 - 8;
  localparam logic [DEC_LOG2-1:0] DCNT_ONE  = {{(DEC_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEC_LOG2-1:0] DCNT_LAST = {DEC_LOG2{1'b1}};
  localparam logic [1:0]          WARM_DONE = 2'd2;

  // Full-scale input gives DECIM**2, one count past the 8-bit range, so clamp.
  function automatic logic [7:0] sat8(input logic [W-1:0] c);
    logic [W-1:0] s;
    s = c >> SHIFT;
    if (|s[W-1:8]) begin
      sat8 = 8'hFF;
    end else begin
      sat8 = s[7:0];
    end
  endfunction

  logic [W-1:0]        int1_q, int1_d, int2_q, int2_d, int2_dly_q, int2_dly_d;
  logic [W-1:0]        c1_q, c1_d, c1_dly_q, c1_dly_d, c2_q, c2_d;
  logic [DEC_LOG2-1:0] dcnt_q, dcnt_d;
  logic                load_q, load_d;
  logic [1:0]          warm_q, warm_d;
  logic [7:0]          sample_q, sample_d;
  logic                valid_q, valid_d, ovr_q, ovr_d;
  logic [31:0]         rd_data_q, rd_data_d;

  logic                tick;
  logic                rd0;
  logic                post_load;
  logic [7:0]          new_sample;
  logic [W-1:0]        din_ext;
  logic [31:0]         status_word;
  logic [31:0]         period_word;

`ifdef ZCROSS_EN
  localparam logic [PER_WIDTH-1:0] PER_MAX  = {PER_WIDTH{1'b1}};
  localparam logic [PER_WIDTH-1:0] PER_ONE  = {{(PER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PER_WIDTH-1:0] PER_ZERO = {PER_WIDTH{1'b0}};
  logic [PER_WIDTH-1:0] pcnt_q, pcnt_d, period_q, period_d;
  logic                 seen_q, seen_d;
  logic                 crossing;
`endif

  // CIC datapath: integrators every clock, combs once per decimation frame.
  always_comb begin
    din_ext  = {{(W-1){1'b0}}, din};
    int1_d   = int1_q + din_ext;
    int2_d   = int2_q + int1_q;
    dcnt_d   = dcnt_q + DCNT_ONE;
    tick     = (dcnt_q == DCNT_LAST);
    load_d   = tick;
    if (tick) begin
      c1_d       = int2_q - int2_dly_q;
      int2_dly_d = int2_q;
      c2_d       = c1_q - c1_dly_q;
      c1_dly_d   = c1_q;
    end else begin
      c1_d       = c1_q;
      int2_dly_d = int2_dly_q;
      c2_d       = c2_q;
      c1_dly_d   = c1_dly_q;
    end
  end

  // Sample capture, warm-up, status flags and the registered read port.
  always_comb begin
    new_sample  = sat8(c2_q);
    post_load   = load_q & (warm_q == WARM_DONE);
    rd0         = ~rd_n & ~addr;
    sample_d    = sample_q;
    warm_d      = warm_q;
    valid_d     = valid_q;
    ovr_d       = ovr_q;

    if (load_q) begin
      sample_d = new_sample;
    end else begin
      sample_d = sample_q;
    end

    if (load_q && (warm_q != WARM_DONE)) begin
      warm_d = warm_q + 2'd1;
    end else begin
      warm_d = warm_q;
    end

    // A read in the load cycle clears the flags first, so the fresh sample lands with ovr=0.
    if (rd0) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
      ovr_d   = ovr_q;
    end
    if (post_load) begin
      valid_d = 1'b1;
      if (valid_q && !rd0) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_d;
      end
    end else begin
      valid_d = valid_d;
    end

    status_word = {valid_q, ovr_q, 22'b0, sample_q};
`ifdef ZCROSS_EN
    period_word = 32'(period_q);
`else
    period_word = 32'h0000_0000;
`endif

    if (!rd_n) begin
      rd_data_d = addr ? period_word : status_word;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

`ifdef ZCROSS_EN
  // Period measurement in decimated samples between rising mid-scale crossings.
  always_comb begin
    crossing = post_load & ~sample_q[7] & new_sample[7];
    pcnt_d   = pcnt_q;
    period_d = period_q;
    seen_d   = seen_q;
    if (crossing) begin
      pcnt_d = PER_ZERO;
      seen_d = 1'b1;
      if (seen_q) begin
        period_d = (pcnt_q == PER_MAX) ? PER_MAX : pcnt_q + PER_ONE;
      end else begin
        period_d = period_q;
      end
    end else if (post_load) begin
      pcnt_d = (pcnt_q == PER_MAX) ? PER_MAX : pcnt_q + PER_ONE;
    end else begin
      pcnt_d = pcnt_q;
    end
  end
`endif

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      int1_q     <= {W{1'b0}};
      int2_q     <= {W{1'b0}};
      int2_dly_q <= {W{1'b0}};
      c1_q       <= {W{1'b0}};
      c1_dly_q   <= {W{1'b0}};
      c2_q       <= {W{1'b0}};
      dcnt_q     <= {DEC_LOG2{1'b0}};
      load_q     <= 1'b0;
      warm_q     <= 2'd0;
      sample_q   <= 8'h00;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      rd_data_q  <= 32'h0000_0000;
`ifdef ZCROSS_EN
      pcnt_q     <= PER_ZERO;
      period_q   <= PER_ZERO;
      seen_q     <= 1'b0;
`endif
    end else begin
      int1_q     <= int1_d;
      int2_q     <= int2_d;
      int2_dly_q <= int2_dly_d;
      c1_q       <= c1_d;
      c1_dly_q   <= c1_dly_d;
      c2_q       <= c2_d;
      dcnt_q     <= dcnt_d;
      load_q     <= load_d;
      warm_q     <= warm_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      rd_data_q  <= rd_data_d;
`ifdef ZCROSS_EN
      pcnt_q     <= pcnt_d;
      period_q   <= period_d;
      seen_q     <= seen_d;
`endif
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sd_demod.sv
// Bench for sd_demod (DEC_LOG2=4): table of bitstream/frame-count vectors plus hand sequences
// for read-on-load, mid-frame clear and the address-1 period word.
module tb_sd_demod;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        din = 1'b0;
  logic        rd_n = 1'b1;
  logic        addr = 1'b0;
  logic [31:0] rd_data;

  sd_demod dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .din     (din),
    .rd_n    (rd_n),
    .addr    (addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    int          nloads;
    logic [31:0] exp_word;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          bit_idx = 0;
  int          mode = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[12];

`ifdef ZCROSS_EN
  localparam logic [31:0] PERIOD_EXP = 32'd8;
`else
  localparam logic [31:0] PERIOD_EXP = 32'd0;
`endif

  // Bit patterns: 0 zeros, 1 ones, 2 alternating 1,0, 3 64 ones / 64 zeros.
  function automatic logic din_of(input int m, input int j);
    case (m)
      0:       din_of = 1'b0;
      1:       din_of = 1'b1;
      2:       din_of = ((j % 2) == 0);
      3:       din_of = (((j / 64) % 2) == 0);
      default: din_of = 1'b0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      din = din_of(mode, bit_idx);
      bit_idx++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    rd_n  = 1'b1;
    din   = 1'b0;
    @(negedge clk);
    clr_n   = 1'b1;
    bit_idx = 0;
    check("reset_rd_data", rd_data, 32'h0000_0000);
  endtask

  task automatic do_read(input logic a, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    addr = a;
    rd_n = 1'b0;
    din  = din_of(mode, bit_idx);
    bit_idx++;
    exp_q.push_back(exp);
    @(negedge clk);
    rd_n = 1'b1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got %08h exp <none queued>", nm, rd_data);
    end else begin
      e = exp_q.pop_front();
      check(nm, rd_data, e);
    end
  endtask

  initial begin
    // Load k (edge 16k+1) = I(k-1) - 2 I(k-2) + I(k-3), I(n) = int2 after edge 16n-1.
    vecs[0]  = '{1, 1, 32'h0000_0000};
    vecs[1]  = '{1, 2, 32'h0000_0069};
    vecs[2]  = '{1, 3, 32'h8000_00FF};
    vecs[3]  = '{1, 4, 32'hC000_00FF};
    vecs[4]  = '{0, 2, 32'h0000_0000};
    vecs[5]  = '{0, 3, 32'h8000_0000};
    vecs[6]  = '{0, 4, 32'hC000_0000};
    vecs[7]  = '{2, 2, 32'h0000_0038};
    vecs[8]  = '{2, 3, 32'h8000_0080};
    vecs[9]  = '{2, 5, 32'hC000_0080};
    vecs[10] = '{3, 6, 32'hC000_0097};
    vecs[11] = '{3, 7, 32'hC000_0001};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      mode = vecs[i].mode;
      do_reset();
      step(16 * vecs[i].nloads + 2);
      do_read(1'b0, vecs[i].exp_word, $sformatf("vec%0d_read", i));
      do_read(1'b0, vecs[i].exp_word & 32'h3FFF_FFFF, $sformatf("vec%0d_reread", i));
    end

    // Reads landing exactly on load cycles (edges 49, 65, 81).
    mode = 2;
    do_reset();
    step(48);
    do_read(1'b0, 32'h0000_0038, "load3_rd_old");
    do_read(1'b0, 32'h8000_0080, "load3_rd_new");
    step(14);
    do_read(1'b0, 32'h0000_0080, "load4_rd_old");
    step(15);
    do_read(1'b0, 32'h8000_0080, "load5_rd_old");
    do_read(1'b0, 32'h8000_0080, "load5_no_ovr");
    do_read(1'b0, 32'h0000_0080, "load5_cleared");

    // Clear mid-frame, then warm-up must restart from scratch.
    mode = 1;
    do_reset();
    step(34);
    do_read(1'b0, 32'h0000_0069, "pre_clr_read");
    step(5);
    do_reset();
    do_read(1'b0, 32'h0000_0000, "post_clr_read");
    step(49);
    do_read(1'b0, 32'h8000_00FF, "post_clr_valid");

    // Period word on address 1; address-1 reads leave the flags alone.
    mode = 3;
    do_reset();
    do_read(1'b1, 32'h0000_0000, "period_after_reset");
    step(161);
    do_read(1'b1, 32'h0000_0000, "period_first_cross");
    step(15);
    do_read(1'b1, PERIOD_EXP, "period_second_cross");
    do_read(1'b0, 32'hC000_00FF, "flags_after_addr1");
    step(3);
    check("rd_data_hold", rd_data, 32'hC000_00FF);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
